// File: rtl/sram_bus_arbiter_if.sv
// sram_bus_arbiter_if: sram-like req/addr_ok/data_ok signals for the inst port, the data port and the shared memory port.
interface sram_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              inst_req;
    logic              inst_wr;
    logic [1:0]        inst_size;
    logic [ADDR_W-1:0] inst_addr;
    logic [DATA_W-1:0] inst_wdata;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;
    logic              mem_req;
    logic              mem_wr;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_addr_ok;
    logic              mem_data_ok;
    logic [DATA_W-1:0] mem_rdata;
    // master is the arbiter's view; slave is the requesters plus the memory
    modport master (
        input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );
    modport slave (
        output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one sram-like memory port between inst fetch and data access, data first with bounded inst starvation.
module sram_bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
) (
    input logic                clk,
    input logic                reset,
    sram_bus_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, ADDR, WAIT} state_t;
    state_t            r_state;
    state_t            w_next;
    logic              r_owner;
    logic              r_wr;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_starve_cnt;
    logic              w_idle;
    logic              w_starved;
    logic              w_grant_data;
    logic              w_grant_inst;
    logic              w_grant;
    assign w_idle       = r_state == IDLE;
    assign w_starved    = r_starve_cnt == 4'(STARVE_LIMIT);
    assign w_grant_data = w_idle && bus.data_req && !(bus.inst_req && w_starved);
    assign w_grant_inst = w_idle && bus.inst_req && !w_grant_data;
    assign w_grant      = w_grant_data || w_grant_inst;
    assign bus.mem_wr     = r_wr;
    assign bus.mem_size   = r_size;
    assign bus.mem_addr   = r_addr;
    assign bus.mem_wdata  = r_wdata;
    assign bus.inst_rdata = bus.mem_rdata;
    assign bus.data_rdata = bus.mem_rdata;
    always_comb begin
        w_next           = r_state;
        bus.inst_addr_ok = w_grant_inst;
        bus.data_addr_ok = w_grant_data;
        bus.mem_req      = r_state == ADDR;
        bus.inst_data_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        case (r_state)
            IDLE: w_next = w_grant ? ADDR : IDLE;
            ADDR: w_next = bus.mem_addr_ok ? WAIT : ADDR;
            WAIT: begin
                bus.inst_data_ok = !r_owner && bus.mem_data_ok;
                bus.data_data_ok = r_owner && bus.mem_data_ok;
                w_next           = bus.mem_data_ok ? IDLE : WAIT;
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_wr         <= 1'b0;
            r_size       <= 2'd0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_starve_cnt <= 4'd0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_owner      <= w_grant_data;
                r_wr         <= w_grant_data ? bus.data_wr : bus.inst_wr;
                r_size       <= w_grant_data ? bus.data_size : bus.inst_size;
                r_addr       <= w_grant_data ? bus.data_addr : bus.inst_addr;
                r_wdata      <= w_grant_data ? bus.data_wdata : bus.inst_wdata;
                // only a data win over a waiting inst request counts toward starvation
                r_starve_cnt <= (w_grant_data && bus.inst_req) ? (w_starved ? r_starve_cnt : r_starve_cnt + 4'd1) : 4'd0;
            end
        end
    end
endmodule
